// File: rtl/axi4_mem_pkg.sv
// Shared response codes and FSM state types for the AXI4 slave memory.
package axi4_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } write_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } read_state_e;

endpackage

// File: rtl/axi4_mem_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one synchronous read
// port with one cycle of latency. A read and a write of the same word in the
// same cycle return the old contents. The read register only changes when
// re_i is high, so read data holds while the consumer stalls.
module axi4_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-enabled write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; holds its value while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: INCR bursts of full-width beats into on-chip RAM.
// Write and read channels run independently, one transaction each.
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are high; valid and its payload stay stable
// until that edge. All ready/valid outputs come from registers or state.
module axi4_slave_mem
  import axi4_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 2,
  parameter int DEPTH  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ID_W-1:0]      s_axi_awid,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic [7:0]           s_axi_awlen,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATA_W-1:0]    s_axi_wdata,
  input  logic [DATA_W/8-1:0]  s_axi_wstrb,
  input  logic                 s_axi_wlast,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [ID_W-1:0]      s_axi_bid,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ID_W-1:0]      s_axi_arid,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  input  logic [7:0]           s_axi_arlen,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [ID_W-1:0]      s_axi_rid,
  output logic [DATA_W-1:0]    s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rlast,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output write_state_e         w_state_o,
  output read_state_e          r_state_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int WA_W  = ADDR_W - LSB;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WA_W-1:0] DEPTH_WORDS = WA_W'(DEPTH);

  // ---------------- write channel ----------------
  write_state_e     w_state_q, w_state_d;
  logic             awready_q;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic [WA_W-1:0]  waddr_q, waddr_d;
  logic [7:0]       wlen_q, wlen_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic             werr_q, werr_d;
  logic             w_in_range;
  logic             ram_we;

  assign w_in_range = (waddr_q < DEPTH_WORDS);

  // Write FSM next state: accept AW, absorb beats until wlast, then respond.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          bid_d     = s_axi_awid;
          waddr_d   = s_axi_awaddr[ADDR_W-1:LSB];
          wlen_d    = s_axi_awlen;
          wcnt_d    = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          ram_we  = w_in_range;
          if (!w_in_range) werr_d = 1'b1;
          waddr_d = waddr_q + WA_W'(1);
          wcnt_d  = wcnt_q + 9'd1;
          if (s_axi_wlast) begin
            // A burst that ends early or late is reported as an error.
            if (wcnt_q != {1'b0, wlen_q}) werr_d = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers; awready is registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = s_axi_bvalid ? bid_q : '0;
  assign s_axi_bresp   = (s_axi_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign w_state_o     = w_state_q;

  // ---------------- read channel ----------------
  read_state_e      r_state_q, r_state_d;
  logic             arready_q;
  logic [ID_W-1:0]  rid_q, rid_d;
  logic [WA_W-1:0]  raddr_q, raddr_d;
  logic [7:0]       rlen_q, rlen_d;
  logic [8:0]       rcnt_q, rcnt_d;
  logic             r_in_range;
  logic             r_last;
  logic [DATA_W-1:0] ram_rdata;

  assign r_in_range = (raddr_q < DEPTH_WORDS);
  assign r_last     = (rcnt_q == {1'b0, rlen_q});

  // Read FSM next state: fetch one word, present it, repeat until rlast.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rid_d     = s_axi_arid;
          raddr_d   = s_axi_araddr[ADDR_W-1:LSB];
          rlen_d    = s_axi_arlen;
          rcnt_d    = '0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (s_axi_rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d   = raddr_q + WA_W'(1);
            rcnt_d    = rcnt_q + 9'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers; arready is registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = s_axi_rvalid ? rid_q : '0;
  assign s_axi_rlast   = s_axi_rvalid && r_last;
  assign s_axi_rresp   = (s_axi_rvalid && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rdata   = (s_axi_rvalid && r_in_range) ? ram_rdata : '0;
  assign r_state_o     = r_state_q;

  // Sub-word address bits carry no meaning for full-width beats.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  axi4_mem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(waddr_q[IDX_W-1:0]),
    .wdata_i(s_axi_wdata),
    .wstrb_i(s_axi_wstrb),
    .re_i   ((r_state_q == R_FETCH) && r_in_range),
    .raddr_i(raddr_q[IDX_W-1:0]),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: directed vector table, hand-written corner
// sequences and randomized traffic checked against a word-array memory model.
module tb_axi4_slave_mem;
  import axi4_mem_pkg::*;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni;

  logic [1:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic awvalid; logic awready;
  logic [31:0] wdata;  logic [3:0]  wstrb;  logic wlast; logic wvalid; logic wready;
  logic [1:0]  bid;    logic [1:0]  bresp;  logic bvalid; logic bready;
  logic [1:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic arvalid; logic arready;
  logic [1:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast; logic rvalid; logic rready;
  write_state_e w_state;
  read_state_e  r_state;

  axi4_slave_mem #(.DATA_W(32), .ADDR_W(32), .ID_W(2), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .w_state_o(w_state), .r_state_o(r_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wbuf[$];
  logic [3:0]  sbuf[$];
  logic [31:0] model_mem [int];

  logic [31:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];
  logic        rd_last_q[$];
  logic [1:0]  rd_id_q[$];
  int          rd_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not occur within the cycle budget", name);
  endtask

  function automatic void model_write(input logic [31:0] addr, input int nbeats);
    int w;
    logic [31:0] v;
    for (int b = 0; b < nbeats; b++) begin
      w = int'(addr >> 2) + b;
      if (w < DEPTH) begin
        v = model_mem.exists(w) ? model_mem[w] : 32'h0;
        for (int k = 0; k < 4; k++)
          if (sbuf[b][k]) v[8*k +: 8] = wbuf[b][8*k +: 8];
        model_mem[w] = v;
      end
    end
  endfunction

  function automatic logic [31:0] model_rd(input int w);
    if (w >= DEPTH) return 32'h0;
    return model_mem.exists(w) ? model_mem[w] : 32'h0;
  endfunction

  // ---------------- driver tasks ----------------
  // All driving and sampling happens on the falling edge.
  task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input int len,
                          input int nbeats, output logic [1:0] resp, output logic [1:0] bid_v,
                          output int cyc);
    int guard;
    resp = 2'b11; bid_v = 2'b00; cyc = 0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 200) begin @(negedge clk); guard++; end
    if (!awready) begin report_timeout("aw_wait"); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    cyc = 1;  // the AW handshake cycle
    for (int b = 0; b < nbeats; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 200) begin @(negedge clk); cyc++; guard++; end
      if (!wready) begin report_timeout("w_wait"); wvalid = 1'b0; return; end
      @(negedge clk);
      cyc++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    guard = 0;
    while (!bvalid && guard < 200) begin @(negedge clk); cyc++; guard++; end
    if (!bvalid) begin report_timeout("b_wait"); return; end
    resp = bresp; bid_v = bid;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input int len,
                         input int hold, input logic [31:0] exp_hold);
    int guard;
    rd_data_q.delete(); rd_resp_q.delete(); rd_last_q.delete(); rd_id_q.delete();
    rd_lat = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 200) begin @(negedge clk); guard++; end
    if (!arready) begin report_timeout("ar_wait"); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    rd_lat = 1;
    for (int b = 0; b <= len; b++) begin
      guard = 0;
      while (!rvalid && guard < 200) begin
        @(negedge clk); guard++;
        if (b == 0) rd_lat++;
      end
      if (!rvalid) begin report_timeout("r_wait"); return; end
      rd_data_q.push_back(rdata); rd_resp_q.push_back(rresp);
      rd_last_q.push_back(rlast); rd_id_q.push_back(rid);
      if (b == 0) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          chk("hold_rvalid", rvalid, 1);
          chk("hold_rdata", rdata, exp_hold);
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic write_and_check(input string name, input logic [1:0] id, input logic [31:0] addr,
                                 input int len, input int nbeats, input logic [1:0] exp_resp);
    logic [1:0] resp;
    logic [1:0] bid_v;
    int cyc;
    do_write(id, addr, len, nbeats, resp, bid_v, cyc);
    chk({name, "_bresp"}, resp, exp_resp);
    chk({name, "_bid"}, bid_v, id);
    // IDLE -> IDLE takes 1 (AW) + one cycle per beat + 1 (B) with no stalls.
    chk({name, "_cycles"}, cyc, nbeats + 2);
    chk({name, "_awready_back"}, awready, 1);
    model_write(addr, nbeats);
  endtask

  task automatic check_read(input string name, input logic [1:0] id, input logic [31:0] addr,
                            input int len, input int hold);
    int w0;
    int w;
    w0 = int'(addr >> 2);
    do_read(id, addr, len, hold, model_rd(w0));
    chk({name, "_latency"}, rd_lat, 2);
    chk({name, "_beats"}, rd_data_q.size(), len + 1);
    for (int b = 0; b < rd_data_q.size(); b++) begin
      w = w0 + b;
      chk({name, "_rdata"}, rd_data_q[b], model_rd(w));
      chk({name, "_rresp"}, rd_resp_q[b], (w < DEPTH) ? 2'b00 : 2'b10);
      chk({name, "_rlast"}, rd_last_q[b], (b == len));
      chk({name, "_rid"}, rd_id_q[b], id);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [31:0] base;       // beat b carries base*(b+1)
    logic [3:0]  strb;
    logic [1:0]  id;
    bit          do_wr;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata0; // first read-back beat
    logic [1:0]  exp_rresp0;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [45:0] outs;
    int len;
    int w;
    logic [1:0] id;

    vecs[0] = '{32'h10,  0, 32'h0000ABCD, 4'hF, 2'd1, 1'b1, 2'b00, 32'h0000ABCD, 2'b00};
    vecs[1] = '{32'h40,  3, 32'h11111111, 4'hF, 2'd2, 1'b1, 2'b00, 32'h11111111, 2'b00};
    vecs[2] = '{32'(DEPTH*4-4), 1, 32'h5A5A0001, 4'hF, 2'd3, 1'b1, 2'b10, 32'h5A5A0001, 2'b00};
    vecs[3] = '{32'(DEPTH*4), 0, 32'h0, 4'hF, 2'd0, 1'b0, 2'b00, 32'h0, 2'b10};
    vecs[4] = '{32'(DEPTH*4), 0, 32'h12345678, 4'hF, 2'd1, 1'b1, 2'b10, 32'h0, 2'b10};

    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 1'b1;
    arid = 0; araddr = 0; arlen = 0; arvalid = 0; rready = 0;

    // Reset: every output low while reset is held, readies rise one cycle after.
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    outs = {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast};
    chk("reset_outputs", outs, 46'h0);
    chk("reset_w_state", w_state, W_IDLE);
    chk("reset_r_state", r_state, R_IDLE);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("reset_awready_rise", awready, 1);
    chk("reset_arready_rise", arready, 1);

    // Table of single transfers and error boundaries.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_wr) begin
        wbuf.delete(); sbuf.delete();
        for (int b = 0; b <= vecs[i].len; b++) begin
          wbuf.push_back(vecs[i].base * 32'(b + 1));
          sbuf.push_back(vecs[i].strb);
        end
        write_and_check($sformatf("vec%0d_wr", i), vecs[i].id, vecs[i].addr,
                        vecs[i].len, vecs[i].len + 1, vecs[i].exp_bresp);
      end
      check_read($sformatf("vec%0d_rd", i), vecs[i].id, vecs[i].addr, vecs[i].len, 0);
      if (rd_data_q.size() > 0) begin
        chk($sformatf("vec%0d_rdata0", i), rd_data_q[0], vecs[i].exp_rdata0);
        chk($sformatf("vec%0d_rresp0", i), rd_resp_q[0], vecs[i].exp_rresp0);
      end
    end
    chk("vec1_beat3", model_rd(32'h4C >> 2), 32'h44444444);

    // Strobes and read backpressure.
    wbuf = '{32'hFFFFFFFF}; sbuf = '{4'hF};
    write_and_check("strb_full", 2'd0, 32'h8, 0, 1, 2'b00);
    wbuf = '{32'h00000000}; sbuf = '{4'h5};
    write_and_check("strb_part", 2'd0, 32'h8, 0, 1, 2'b00);
    check_read("strb_rd", 2'd1, 32'h8, 0, 5);
    if (rd_data_q.size() > 0) chk("strb_value", rd_data_q[0], 32'hFF00FF00);

    // wlast on beat 2 of a 4-beat burst.
    wbuf = '{32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004};
    sbuf = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_and_check("early_wlast", 2'd1, 32'h80, 3, 2, 2'b10);
    check_read("early_wlast_rd", 2'd1, 32'h80, 1, 0);

    // Overlapping write and read on different addresses.
    wbuf = '{32'hC0DE0001, 32'hC0DE0002}; sbuf = '{4'hF, 4'hF};
    fork
      write_and_check("conc_wr", 2'd2, 32'h200, 1, 2, 2'b00);
      check_read("conc_rd", 2'd3, 32'h40, 1, 0);
    join
    check_read("conc_wr_rd", 2'd0, 32'h200, 1, 0);

    // Longest burst: 256 beats.
    wbuf.delete(); sbuf.delete();
    for (int b = 0; b < 256; b++) begin wbuf.push_back($urandom); sbuf.push_back(4'hF); end
    write_and_check("len255", 2'd1, 32'h400, 255, 256, 2'b00);
    check_read("len255_rd", 2'd2, 32'h400, 255, 0);

    // Reset in the middle of a write burst and a read burst.
    @(negedge clk);
    awid = 2'd1; awaddr = 32'h300; awlen = 8'd7; awvalid = 1'b1;
    arid = 2'd2; araddr = 32'h40;  arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    wdata = 32'hDEAD0001; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    chk("mid_rvalid", rvalid, 1);
    chk("mid_wready", wready, 1);
    wvalid = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    outs = {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast};
    chk("mid_reset_outputs", outs, 46'h0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", awready, 1);
    chk("post_reset_arready", arready, 1);
    chk("post_reset_bvalid", bvalid, 0);
    wbuf = '{32'hDEAD0001}; sbuf = '{4'hF};
    model_write(32'h300, 1);
    wbuf = '{32'hBEEF0002}; sbuf = '{4'hF};
    write_and_check("post_reset_wr", 2'd3, 32'h304, 0, 1, 2'b00);
    check_read("post_reset_rd", 2'd3, 32'h300, 1, 0);

    // Randomized traffic inside an initialized window of words 64..127.
    wbuf.delete(); sbuf.delete();
    for (int b = 0; b < 64; b++) begin wbuf.push_back($urandom); sbuf.push_back(4'hF); end
    write_and_check("rand_init", 2'd0, 32'h100, 63, 64, 2'b00);
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 7);
      w   = $urandom_range(64, 127 - len);
      id  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete(); sbuf.delete();
        for (int b = 0; b <= len; b++) begin
          wbuf.push_back($urandom);
          sbuf.push_back(4'($urandom_range(0, 15)));
        end
        write_and_check($sformatf("rand%0d_wr", it), id, 32'(w * 4), len, len + 1, 2'b00);
      end else begin
        check_read($sformatf("rand%0d_rd", it), id, 32'(w * 4), len, $urandom_range(0, 2));
      end
    end
    check_read("rand_final", 2'd1, 32'h100, 63, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
